aes_cipher_iter: RTL and testbench
==================================

# aes_cipher_iter

Iterative AES encryption datapath; consumes the full round-key bus produced by the key-expansion stage and encrypts one 128-bit block in Nr+1 clocks, one round per cycle. Sits between the SPI receive/assembly logic, which supplies plaintext and start, and the SPI transmit side, which takes ciphertext on done. Key expansion stays combinational and upstream; this block holds no key state.

## Interface
- Nk, 4, key length in 32-bit words (4/6/8); documentation only, must match the upstream stage
- Nr, 10, number of rounds (10/12/14)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- w  in  128*(Nr+1)  round keys; round key r = w[r*128+:128]; word j of a key = [j*32+:32]
- in_block  in  128  plaintext, same packing as one round key
- start  in  1  single-cycle request; sampled when idle
- busy  out  1  high from the edge that accepts start through the final round edge
- done  out  1  one-cycle pulse, ciphertext valid
- out_block  out  128  ciphertext; holds until the next accepted start
- abort  in  1  present only with AES_ABORT_EN

## Operation
- Byte map: column c = bits [c*32+:32]; row r of column c = [c*32+(3-r)*8+:8], i.e. MSB byte is row 0. This matches the key schedule's RotWord/Rcon placement.
- States: IDLE, ROUND.
- IDLE, start=1: state <= in_block ^ rk0; rnd <= 1; enter ROUND; busy=1.
- IDLE, start=0: hold; outputs unchanged.
- ROUND, rnd<Nr: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[rnd]; rnd <= rnd+1.
- ROUND, rnd==Nr: state <= ShiftRows(SubBytes(state)) ^ rk[Nr]; load out_block; done <= 1; return to IDLE.
- SubBytes uses 16 instances of the existing S_Box. MixColumns is GF(2^8) with xtime (poly 0x11B). ShiftRows rotates row r left by r columns.
- rnd counter is 4 bits. Round-key select is a mux over rnd; there is no arithmetic wrap beyond Nr.
- A start asserted while busy is ignored, with no queuing and no error.
- w must be stable from the start cycle through the done cycle; this is the caller's responsibility and is not checked.
- in_block is sampled only on the accepting edge.

## Timing
- Reset values: busy=0, done=0, out_block=0, internal state=0, rnd=0, FSM=IDLE.
- Reset mid-operation clears everything immediately and asynchronously. No done is issued.
- Start accepted at edge E0. The rounds complete at edges E1..ENr.
- done is high for exactly the cycle after ENr. Latency from start to done is Nr+1 cycles: 11 for Nr=10, 15 for Nr=14.
- busy is high for the cycles after E0..E(Nr-1) and falls together with the rise of done.
- Back-to-back: start asserted during the done cycle is accepted. The next done follows Nr+1 cycles later, giving a throughput of one block per Nr+1 cycles.
- out_block changes only at the final-round edge.

## Configuration
- AES_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 in ROUND: next edge returns to IDLE with busy=0, and done is not pulsed.
  - out_block keeps its previous value.
  - abort has priority over the final-round load.
  - abort in IDLE has no effect. start and abort together in IDLE: start wins.
- AES_ABORT_EN undefined: the port does not exist and the FSM has no abort path.

## Test plan
- Test vectors are given in FIPS-197 byte order; the bench packs FIPS word j into bits [j*32+:32].
- FIPS-197 C.1: key 000102…0f, pt 00112233…eeff, key expansion driving w, pulse start → done 11 cycles later, out_block = 69c4e0d8 6a7b0430 d8cdb780 70b4c55a, busy low on done cycle.
- FIPS-197 App.B: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, pt 3243f6a8 885a308d 313198a2 e0370734 → ct 3925841d 02dc09fb dc118597 196a0b32; out_block held stable for 20 idle cycles afterward.
- Nr=14, Nk=8 (FIPS C.3): key 00…1f, pt 00112233…eeff → 8ea2b7ca 516745bf eafc4990 4b496089 after 15 cycles.
- Start re-pulsed at cycles 3 and 7 of an operation → ignored, single done, correct ct; then start in the done cycle → second correct ct 11 cycles later.
- rst_n pulled low at round 5 → busy/done/out_block = 0 immediately. After release, a new start yields the correct ct.
- AES_ABORT_EN: abort at round 4 → IDLE next edge, no done pulse, out_block equals the previous ct. Start+abort in IDLE → operation starts.

Source files
------------

// File: rtl/aes_cipher_iter_if.sv
// aes_cipher_iter_if: request/response bundle between the SPI-side logic and
// the iterative AES core. The abort signal exists only when AES_ABORT_EN is
// defined.
interface aes_cipher_iter_if #(
    parameter int Nr = 10
);
    logic [128*(Nr+1)-1:0] w;          // all round keys, key r at [r*128+:128]
    logic [127:0]          in_block;   // plaintext
    logic                  start;      // one-cycle request, sampled when idle
    logic                  busy;       // operation in flight
    logic                  done;       // one-cycle ciphertext-valid pulse
    logic [127:0]          out_block;  // ciphertext, held until next final round
`ifdef AES_ABORT_EN
    logic                  abort;      // cancel the operation in flight
`endif

    modport master (
        output w, in_block, start,
`ifdef AES_ABORT_EN
        output abort,
`endif
        input  busy, done, out_block
    );

    modport slave (
        input  w, in_block, start,
`ifdef AES_ABORT_EN
        input  abort,
`endif
        output busy, done, out_block
    );
endinterface

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryption core, one round per clock.
// Round keys come in on the bus fully expanded; no key state is held here.
// Define AES_ABORT_EN to add an abort input that cancels a running block.
module aes_cipher_iter #(
    parameter int Nk = 4,   // key words; must agree with the upstream key schedule
    parameter int Nr = 10   // rounds
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_cipher_iter_if.slave bus
);

    if (Nr != Nk + 6) begin : g_bad_cfg
        $error("aes_cipher_iter: Nr must equal Nk+6");
    end

    typedef enum logic {IDLE, ROUND} state_e;

    state_e       fsm_q, fsm_d;
    logic [127:0] st_q, st_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;

    logic [127:0] sb, sr, mc, rk;
    logic [7:0]   a0, a1, a2, a3;

    // GF(2^8) multiply, reduction polynomial 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S_Box: multiplicative inverse as a^254 (0 maps to 0), then the affine map
    function automatic logic [7:0] s_box(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] inv;
        t   = gmul(a, a);
        inv = t;
        for (int k = 0; k < 6; k++) begin
            t   = gmul(t, t);
            inv = gmul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubBytes: one S_Box per state byte
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign sb[i*8 +: 8] = s_box(st_q[i*8 +: 8]);
    end

    // ShiftRows then MixColumns; row 0 is the MSB byte of each column
    always_comb begin
        sr = '0;
        mc = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[c*32 + (3-r)*8 +: 8] = sb[((c+r)%4)*32 + (3-r)*8 +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[c*32+24 +: 8];
            a1 = sr[c*32+16 +: 8];
            a2 = sr[c*32+8  +: 8];
            a3 = sr[c*32    +: 8];
            mc[c*32+24 +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            mc[c*32+16 +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            mc[c*32+8  +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            mc[c*32    +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
    end

    // Round-key select: plain mux over the round counter
    always_comb begin
        rk = '0;
        for (int r = 0; r <= Nr; r++) begin
            if (rnd_q == 4'(r)) rk = bus.w[r*128 +: 128];
        end
    end

    // Next-state: initial AddRoundKey on accept, one round per cycle after
    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        rnd_d  = rnd_q;
        out_d  = out_q;
        done_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    st_d  = bus.in_block ^ bus.w[127:0];
                    rnd_d = 4'd1;
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
`ifdef AES_ABORT_EN
                if (bus.abort) begin
                    fsm_d = IDLE;
                end else begin
`else
                begin
`endif
                    if (rnd_q == 4'(Nr)) begin
                        st_d   = sr ^ rk;
                        out_d  = sr ^ rk;
                        done_d = 1'b1;
                        fsm_d  = IDLE;
                    end else begin
                        st_d  = mc ^ rk;
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            st_q   <= '0;
            rnd_q  <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            rnd_q  <= rnd_d;
            out_q  <= out_d;
            done_q <= done_d;
        end
    end

    assign bus.busy      = (fsm_q == ROUND);
    assign bus.done      = done_q;
    assign bus.out_block = out_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: checks an Nr=10 and an Nr=14 core against a byte-level
// AES model and a block-level timing model (an accepted block finishes Nr
// edges later). FIPS-197 vectors pin the model; random traffic exercises both.
module tb_aes_cipher_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_cipher_iter_if #(.Nr(10)) if10 ();
    aes_cipher_iter_if #(.Nr(14)) if14 ();

    aes_cipher_iter #(.Nk(4), .Nr(10)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(if10));
    aes_cipher_iter #(.Nk(8), .Nr(14)) u_dut14 (.clk(clk), .rst_n(rst_n), .bus(if14));

    logic [128*15-1:0] w_s     [2];
    logic [127:0]      pt_s    [2];
    logic              start_s [2];
    logic              abort_s [2];
    logic              busy_s  [2];
    logic              done_s  [2];
    logic [127:0]      out_s   [2];

    assign if10.w        = w_s[0][128*11-1:0];
    assign if10.in_block = pt_s[0];
    assign if10.start    = start_s[0];
    assign if14.w        = w_s[1];
    assign if14.in_block = pt_s[1];
    assign if14.start    = start_s[1];
`ifdef AES_ABORT_EN
    assign if10.abort    = abort_s[0];
    assign if14.abort    = abort_s[1];
`endif
    assign busy_s[0] = if10.busy;
    assign done_s[0] = if10.done;
    assign out_s[0]  = if10.out_block;
    assign busy_s[1] = if14.busy;
    assign done_s[1] = if14.done;
    assign out_s[1]  = if14.out_block;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;
    logic [7:0] sbox_t [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // byte n of a block in FIPS order: column n/4, row n%4, row 0 = MSB
    function automatic logic [7:0] gb(input logic [127:0] v, input int n);
        return v[(n/4)*32 + (3 - n%4)*8 +: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    function automatic logic [128*15-1:0] expand(input logic [255:0] key, input int nk);
        logic [31:0] W [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [128*15-1:0] r;
        int nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        r  = '0;
        for (int i = 0; i < nk; i++) W[i] = key[i*32 +: 32];
        for (int i = nk; i < nw; i++) begin
            tmp = W[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = m_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            W[i] = W[i-nk] ^ tmp;
        end
        for (int i = 0; i < nw; i++) r[i*32 +: 32] = W[i];
        return r;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [128*15-1:0] wv, input int nr, input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] rk, res;
        rk = wv[127:0];
        for (int n = 0; n < 16; n++) s[n] = gb(pt, n) ^ gb(rk, n);
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[c*4+r] = sbox_t[s[((c+r)%4)*4 + r]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rd < nr)
                        s[c*4+r] = m_mul(8'h02, t[c*4+r]) ^ m_mul(8'h03, t[c*4+(r+1)%4])
                                 ^ t[c*4+(r+2)%4] ^ t[c*4+(r+3)%4];
                    else
                        s[c*4+r] = t[c*4+r];
            rk = wv[rd*128 +: 128];
            for (int n = 0; n < 16; n++) s[n] ^= gb(rk, n);
        end
        res = '0;
        for (int n = 0; n < 16; n++) res[(n/4)*32 + (3 - n%4)*8 +: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] pk(input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // Timing model: an accepted block completes Nr edges later, unless aborted
    int           m_left [2];
    logic         m_done [2];
    logic [127:0] m_out  [2];
    logic [127:0] m_pend [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_left[k] <= 0;
                m_done[k] <= 1'b0;
                m_out[k]  <= '0;
            end else begin
                m_done[k] <= 1'b0;
                if (m_left[k] != 0) begin
                    if (abort_s[k]) begin
                        m_left[k] <= 0;
                    end else begin
                        m_left[k] <= m_left[k] - 1;
                        if (m_left[k] == 1) begin
                            m_done[k] <= 1'b1;
                            m_out[k]  <= m_pend[k];
                        end
                    end
                end else if (start_s[k]) begin
                    m_left[k] <= (k == 0) ? 10 : 14;
                    m_pend[k] <= aes_ref(w_s[k], (k == 0) ? 10 : 14, pt_s[k]);
                end
            end
        end
    end

    // Per-cycle comparison of both cores against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("busy%0d", k), 128'(busy_s[k]), 128'(m_left[k] != 0));
                check($sformatf("done%0d", k), 128'(done_s[k]), 128'(m_done[k]));
                check($sformatf("out%0d", k), out_s[k], m_out[k]);
            end
        end
    end

    task automatic wait_done(input int k, inout int cnt);
        while (!done_s[k] && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic run_op(input int k, input logic [255:0] key, input int nk, input logic [127:0] pt,
                          input logic [127:0] exp_ct, input int exp_lat, input string tag);
        int cnt;
        w_s[k]     = expand(key, nk);
        pt_s[k]    = pt;
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        cnt = 1;
        wait_done(k, cnt);
        check({tag, "_lat"}, 128'(cnt), 128'(exp_lat));
        check({tag, "_ct"}, out_s[k], exp_ct);
        check({tag, "_busy"}, 128'(busy_s[k]), 128'(0));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_s[0] || busy_s[1]) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 128'(busy_s[0] | busy_s[1]), 128'(0));
    endtask

    logic [255:0] k_c1, k_b, k_c3;
    logic [127:0] pt_c1, pt_b, ct_c1, ct_b, ct_c3, pt2;
    logic [7:0]   inv, sv, aff;
    int           cnt;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; abort_s[k] = 1'b0; pt_s[k] = '0; w_s[k] = '0;
        end
        // S-box from first principles: brute-force inverse, then affine map
        aff = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                sv[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ aff[i];
            sbox_t[a] = sv;
        end
        k_c1  = {128'h0, pk(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f)};
        pt_c1 = pk(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
        ct_c1 = pk(32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a);
        k_b   = {128'h0, pk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c)};
        pt_b  = pk(32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734);
        ct_b  = pk(32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32);
        k_c3  = {pk(32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f),
                 pk(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f)};
        ct_c3 = pk(32'h8ea2b7ca, 32'h516745bf, 32'heafc4990, 32'h4b496089);

        // model pins
        check("sbox_00", 128'(sbox_t[8'h00]), 128'h63);
        check("sbox_53", 128'(sbox_t[8'h53]), 128'hed);
        check("model_c1", aes_ref(expand(k_c1, 4), 10, pt_c1), ct_c1);
        check("model_b",  aes_ref(expand(k_b, 4), 10, pt_b), ct_b);
        check("model_c3", aes_ref(expand(k_c3, 8), 14, pt_c1), ct_c3);

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 128'(busy_s[0]), 128'(0));
        check("rst_done", 128'(done_s[0]), 128'(0));
        check("rst_out",  out_s[0], 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, k_c1, 4, pt_c1, ct_c1, 11, "c1");
        run_op(0, k_b, 4, pt_b, ct_b, 11, "appb");
        repeat (20) begin
            @(negedge clk);
            check("appb_hold", out_s[0], ct_b);
        end
        run_op(1, k_c3, 8, pt_c1, ct_c3, 15, "c3");

        // start re-pulsed at cycles 3 and 7 is ignored; start in done cycle accepted
        w_s[0] = expand(k_c1, 4); pt_s[0] = pt_c1; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        pt_s[0] = {$urandom, $urandom, $urandom, $urandom}; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        pt_s[0] = {$urandom, $urandom, $urandom, $urandom}; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        cnt = 8;
        wait_done(0, cnt);
        check("repulse_lat", 128'(cnt), 128'(11));
        check("repulse_ct", out_s[0], ct_c1);
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        pt_s[0] = pt2; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        cnt = 1;
        wait_done(0, cnt);
        check("b2b_lat", 128'(cnt), 128'(11));
        check("b2b_ct", out_s[0], aes_ref(w_s[0], 10, pt2));

        // asynchronous reset in the middle of round 5
        pt_s[0] = pt_b; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy_s[0]), 128'(0));
        check("arst_done", 128'(done_s[0]), 128'(0));
        check("arst_out",  out_s[0], 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, k_c1, 4, pt_c1, ct_c1, 11, "post_rst");

`ifdef AES_ABORT_EN
        // abort at round 4: no done, previous ciphertext kept
        pt_s[0] = pt_b; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk); abort_s[0] = 1'b0;
        check("abort_busy", 128'(busy_s[0]), 128'(0));
        check("abort_out", out_s[0], ct_c1);
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_s[0]) cnt++;
        end
        check("abort_nodone", 128'(cnt), 128'(0));
        // start and abort together in IDLE: start wins
        pt_s[0] = pt_b; start_s[0] = 1'b1; abort_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0; abort_s[0] = 1'b0;
        check("startabort_busy", 128'(busy_s[0]), 128'(1));
        cnt = 1;
        wait_done(0, cnt);
        check("startabort_lat", 128'(cnt), 128'(11));
        check("startabort_ct", out_s[0], aes_ref(w_s[0], 10, pt_b));
`endif

        // random traffic: key fixed per phase, start and plaintext random each cycle
        for (int ph = 0; ph < 3; ph++) begin
            wait_idle();
            w_s[0] = expand({128'h0, $urandom, $urandom, $urandom, $urandom}, 4);
            w_s[1] = expand({$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom}, 8);
            repeat (150) begin
                for (int k = 0; k < 2; k++) begin
                    start_s[k] = ($urandom_range(0, 3) == 0);
                    pt_s[k]    = {$urandom, $urandom, $urandom, $urandom};
                end
                @(negedge clk);
            end
            start_s[0] = 1'b0;
            start_s[1] = 1'b0;
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
